switch_debouncer: RTL and testbench

- Conditions raw board switches (e.g. up_down_sw, manual count enable) before they reach up_down_counter.
- Per switch bit:
  - 2-flop synchroniser;
  - stability counter / state machine that changes the clean level only after DEBOUNCE_CYCLES consecutive stable samples;
  - one-cycle rise and fall pulses.
- Sits directly upstream of the counter; sw_db[0] drives up_down_sw.

---
 rtl/switch_debouncer_pkg.sv | 20 ++
 rtl/switch_debouncer_debounce_channel.sv | 95 +++++++++
 rtl/switch_debouncer.sv | 30 +++
 tb/tb_switch_debouncer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared state encoding and debounce defaults for the switch debouncer.
// The state encoding keeps bit 1 equal to the debounced level.
package switch_debouncer_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      ARM_HI    = 2'b01,
      STABLE_HI = 2'b11,
      ARM_LO    = 2'b10
   } db_state_e;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
   localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;

   // Debounced level carried by a given state.
   function automatic logic state_level(input db_state_e s);
      return (s == STABLE_HI) || (s == ARM_LO);
   endfunction

endpackage

// File: rtl/switch_debouncer_debounce_channel.sv
// Single-bit debouncer: 2-flop synchroniser, stability FSM and counter,
// with registered level and one-cycle rise/fall pulses.
module debounce_channel
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_in,
   output logic sw_db,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_q, s2_q;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         STABLE_LO: begin
            if (s2_q) begin
               state_d = ARM_HI;
               cnt_d   = CNT_ONE;
            end
         end
         ARM_HI: begin
            if (!s2_q) begin
               state_d = STABLE_LO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s2_q) begin
               state_d = ARM_LO;
               cnt_d   = CNT_ONE;
            end
         end
         ARM_LO: begin
            if (s2_q) begin
               state_d = STABLE_HI;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = STABLE_LO;
      endcase
      db_d = state_level(state_d);
   end

   // Only the second synchroniser flop is observed by the FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= sw_in;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign sw_db   = db_q;
   assign sw_rise = rise_q;
   assign sw_fall = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_SW raw board switches in parallel; sw_db[0] feeds the
// counter's up_down_sw input.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned N_SW            = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_SW-1:0] sw_in,
   output logic [N_SW-1:0] sw_db,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall
);

   for (genvar g = 0; g < N_SW; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .sw_in   (sw_in[g]),
         .sw_db   (sw_db[g]),
         .sw_rise (sw_rise[g]),
         .sw_fall (sw_fall[g])
      );
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with N_SW=2, DEBOUNCE_CYCLES=4.
module tb_switch_debouncer;

   localparam int unsigned N_SW = 2;
   localparam int unsigned DB   = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N_SW-1:0] sw_in;
   logic [N_SW-1:0] sw_db, sw_rise, sw_fall;

   int n_checks = 0;
   int n_errors = 0;
   int rise_cnt [2] = '{0, 0};
   int fall_cnt [2] = '{0, 0};
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   switch_debouncer #(
      .N_SW            (N_SW),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sw_in   (sw_in),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Inputs were just changed after an edge: the level must flip exactly
   // on the sixth edge (first sampling edge + DB + 1) with a one-cycle pulse.
   task automatic expect_edge(input string tag, input logic [1:0] db_before,
                              input logic [1:0] db_after, input logic [1:0] r_exp,
                              input logic [1:0] f_exp);
      step(5);
      check_val({tag, "_db_pre"}, sw_db, db_before);
      step(1);
      check_val({tag, "_db"}, sw_db, db_after);
      check_val({tag, "_rise"}, sw_rise, r_exp);
      check_val({tag, "_fall"}, sw_fall, f_exp);
      step(1);
      check_val({tag, "_pulse_end"}, {sw_rise, sw_fall}, 4'b0000);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check_val("rise_fall_excl", sw_rise & sw_fall, 0);
         for (int i = 0; i < 2; i++) begin
            rise_cnt[i] += int'(sw_rise[i]);
            fall_cnt[i] += int'(sw_fall[i]);
         end
      end
   end

   initial begin
      int r0, f0;
      reset = 1'b1;
      sw_in = 2'b11;

      // reset held for 3 edges with inputs high
      step(1);
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_val("rst_outputs", {sw_db, sw_rise, sw_fall}, 6'b000000);
         if (i < 2) step(1);
      end
      reset = 1'b0;
      expect_edge("rst_release", 2'b00, 2'b11, 2'b11, 2'b00);

      // clean fall / rise / fall on channel 0
      sw_in = 2'b10;
      expect_edge("fall0", 2'b11, 2'b10, 2'b00, 2'b01);
      sw_in = 2'b11;
      expect_edge("rise0", 2'b10, 2'b11, 2'b01, 2'b00);
      sw_in = 2'b10;
      expect_edge("fall0b", 2'b11, 2'b10, 2'b00, 2'b01);

      // 3-cycle high glitch is rejected
      r0 = rise_cnt[0];
      sw_in = 2'b11;
      step(3);
      sw_in = 2'b10;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check_val("glitch_hi_db", sw_db, 2'b10);
      end
      check_val("glitch_hi_rises", rise_cnt[0] - r0, 0);

      // exactly DB-cycle pulse is accepted, then released
      sw_in = 2'b11;
      step(4);
      sw_in = 2'b10;
      step(1);
      check_val("pulse4_db_pre", sw_db, 2'b10);
      step(1);
      check_val("pulse4_db", sw_db, 2'b11);
      check_val("pulse4_rise", sw_rise, 2'b01);
      step(3);
      check_val("pulse4_db_hold", sw_db, 2'b11);
      step(1);
      check_val("pulse4_db_fall", sw_db, 2'b10);
      check_val("pulse4_fall", sw_fall, 2'b01);

      // 3-cycle low dip while high is rejected
      sw_in = 2'b11;
      expect_edge("rise0c", 2'b10, 2'b11, 2'b01, 2'b00);
      f0 = fall_cnt[0];
      sw_in = 2'b10;
      step(3);
      sw_in = 2'b11;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check_val("glitch_lo_db", sw_db, 2'b11);
      end
      check_val("glitch_lo_falls", fall_cnt[0] - f0, 0);

      // bounce train then hold high: one rise only
      sw_in = 2'b10;
      expect_edge("fall0c", 2'b11, 2'b10, 2'b00, 2'b01);
      r0 = rise_cnt[0];
      for (int i = 0; i < 10; i++) begin
         sw_in[0] = (i % 2 == 0);
         step(2);
         check_val("bounce_db", sw_db, 2'b10);
      end
      sw_in[0] = 1'b1;
      expect_edge("bounce_settle", 2'b10, 2'b11, 2'b01, 2'b00);
      step(4);
      check_val("bounce_rises", rise_cnt[0] - r0, 1);

      // simultaneous fall on both channels, then reset mid-debounce on ch1
      sw_in = 2'b00;
      expect_edge("fall_both", 2'b11, 2'b00, 2'b00, 2'b11);
      sw_in = 2'b10;
      step(3);
      reset = 1'b1;
      step(1);
      check_val("rst_mid_outputs", {sw_db, sw_rise, sw_fall}, 6'b000000);
      reset = 1'b0;
      expect_edge("rst_mid_rise1", 2'b00, 2'b10, 2'b10, 2'b00);

      // ch0 rises on schedule while ch1 sees only 1-cycle glitches
      sw_in = 2'b00;
      expect_edge("fall1", 2'b10, 2'b00, 2'b00, 2'b10);
      r0 = rise_cnt[1];
      sw_in = 2'b11;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         check_val("indep_db", sw_db, (i >= 6) ? 2'b01 : 2'b00);
         check_val("indep_rise", sw_rise, (i == 6) ? 2'b01 : 2'b00);
         sw_in[1] = ~sw_in[1];
      end
      check_val("indep_ch1_rises", rise_cnt[1] - r0, 0);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
